// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet geometry, packet type and merge-node FSM states.
package noc_pkg;

    localparam int DW_DEF  = 9;
    localparam int ADDR_W  = 4;
    localparam int ADDR_HI = DW_DEF - 1;
    localparam int ADDR_LO = DW_DEF - ADDR_W;

    typedef logic [DW_DEF-1:0] pkt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_S = 2'd1,
        SEND_D = 2'd2
    } state_t;

    function automatic logic [ADDR_W-1:0] pkt_addr(input pkt_t p);
        return p[ADDR_HI:ADDR_LO];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter. MERGE_RR_EN selects round-robin; otherwise in0 has fixed priority.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

`ifndef MERGE_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
`ifdef MERGE_RR_EN
            // on contention, the input that did not win last time goes next
            grant = last ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
        end
    end

endmodule

// File: rtl/merge_arb_node.sv
// Two-into-one merge node: emits a select token, then the packet, per accepted input.
// Build option: MERGE_RR_EN enables round-robin arbitration (default is fixed priority).
module merge_arb_node
    import noc_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int SW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_valid,
    output logic          in1_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] s_data,
    output logic          s_valid,
    input  logic          s_ready
);

    state_t        state, state_nxt;
    logic [DW-1:0] pkt, pkt_nxt;
    logic          src, src_nxt;
    logic          last, last_nxt;
    logic [1:0]    req, grant;
    logic          accept;

    assign req = {in1_valid, in0_valid};

    rr_arb2 u_arb (
        .req   (req),
        .last  (last),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pkt   <= '0;
            src   <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            pkt   <= pkt_nxt;
            src   <= src_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pkt_nxt   = pkt;
        src_nxt   = src;
        last_nxt  = last;
        accept    = 1'b0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        s_valid   = 1'b0;
        out_valid = 1'b0;
        s_data    = SW'(src);
        out_data  = pkt;

        case (state)
            IDLE: accept = 1'b1;
            SEND_S: begin
                s_valid = 1'b1;
                if (s_ready) state_nxt = SEND_D;
            end
            SEND_D: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // delivering the packet and taking the next one share the same cycle
        if (accept) begin
            in0_ready = grant[0];
            in1_ready = grant[1];
            if (|grant) begin
                pkt_nxt   = grant[1] ? in1_data : in0_data;
                src_nxt   = grant[1];
                last_nxt  = grant[1];
                state_nxt = SEND_S;
            end
        end

        if (reset) begin
            in0_ready = 1'b0;
            in1_ready = 1'b0;
            s_valid   = 1'b0;
            out_valid = 1'b0;
            s_data    = '0;
            out_data  = '0;
        end
    end

endmodule

// File: tb/tb_merge_arb_node.sv
// Scoreboard bench for merge_arb_node: randomized and directed traffic against a packet-level model.
module tb_merge_arb_node;

    localparam int DW = 9;
    localparam int SW = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in0_data, in1_data, out_data;
    logic          in0_valid, in0_ready, in1_valid, in1_ready;
    logic          out_valid, out_ready, s_valid, s_ready;
    logic [SW-1:0] s_data;

    merge_arb_node #(.DW(DW), .SW(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic          src;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];

    // packet-level model: at most one packet held, token goes out before data
    bit   m_has   = 1'b0;
    bit   m_ssent = 1'b0;
    bit   m_last  = 1'b1;
    logic fire0   = 1'b0;
    logic fire1   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst,
                        input bit w0, input logic [DW-1:0] d0,
                        input bit w1, input logic [DW-1:0] d1,
                        input bit sr, input bit orr);
        @(negedge clk);
        reset = rst;
        if (!in0_valid || fire0) begin
            in0_valid = w0;
            in0_data  = w0 ? d0 : '0;
        end
        if (!in1_valid || fire1) begin
            in1_valid = w1;
            in1_data  = w1 ? d1 : '0;
        end
        s_ready   = sr;
        out_ready = orr;
        #3;
        fire0 = in0_valid && in0_ready;
        fire1 = in1_valid && in1_ready;
    endtask

    // monitor: compares DUT outputs against the model each cycle, pops on delivery
    initial begin
        bit   exp_s, exp_o, acc, g0, g1;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                check("rst_in0_ready", 32'(in0_ready), 0);
                check("rst_in1_ready", 32'(in1_ready), 0);
                check("rst_s_valid",   32'(s_valid), 0);
                check("rst_out_valid", 32'(out_valid), 0);
                check("rst_s_data",    32'(s_data), 0);
                check("rst_out_data",  32'(out_data), 0);
                sbq.delete();
                m_has   = 1'b0;
                m_ssent = 1'b0;
                m_last  = 1'b1;
            end else begin
                exp_s = m_has && !m_ssent;
                exp_o = m_has && m_ssent;
                check("s_valid",   32'(s_valid), 32'(exp_s));
                check("out_valid", 32'(out_valid), 32'(exp_o));
                check("ready_excl", 32'(in0_ready & in1_ready), 0);

                acc = !m_has || (m_ssent && out_ready);
                g0  = 1'b0;
                g1  = 1'b0;
                if (acc) begin
                    if (in0_valid && in1_valid) begin
`ifdef MERGE_RR_EN
                        g0 = m_last;
                        g1 = !m_last;
`else
                        g0 = 1'b1;
`endif
                    end else begin
                        g0 = in0_valid;
                        g1 = in1_valid;
                    end
                end
                check("in0_ready", 32'(in0_ready), 32'(g0));
                check("in1_ready", 32'(in1_ready), 32'(g1));

                if (exp_s && sbq.size() > 0)
                    check("s_data", 32'(s_data), 32'(sbq[0].src));
                if (exp_o && sbq.size() > 0)
                    check("out_data", 32'(out_data), 32'(sbq[0].data));

                if (exp_o && out_ready) begin
                    if (sbq.size() > 0) void'(sbq.pop_front());
                    m_has = 1'b0;
                end
                if (exp_s && s_ready) m_ssent = 1'b1;
                if (g0 || g1) begin
                    e.src  = g1;
                    e.data = g1 ? in1_data : in0_data;
                    sbq.push_back(e);
                    m_has   = 1'b1;
                    m_ssent = 1'b0;
                    m_last  = g1;
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
        s_ready   = 1'b0;
        out_ready = 1'b0;

        repeat (3) step(1, 0, '0, 0, '0, 1, 1);

        // lone input
        step(0, 1, 9'h1A5, 0, '0, 1, 1);
        repeat (4) step(0, 0, '0, 0, '0, 1, 1);

        // continuous contention
        repeat (10) step(0, 1, 9'h101, 1, 9'h0F2, 1, 1);
        repeat (6) step(0, 0, '0, 0, '0, 1, 1);

        // data-channel backpressure
        step(0, 1, 9'h0AA, 0, '0, 1, 0);
        step(0, 1, 9'h155, 0, '0, 1, 0);
        repeat (5) step(0, 1, 9'h155, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 1, 1);
        repeat (4) step(0, 0, '0, 0, '0, 1, 1);

        // token-channel backpressure
        step(0, 1, 9'h033, 0, '0, 0, 1);
        repeat (3) step(0, 0, '0, 0, '0, 0, 1);
        repeat (4) step(0, 0, '0, 0, '0, 1, 1);

        // reset while a token is pending
        step(0, 1, 9'h0C3, 0, '0, 1, 1);
        step(1, 1, 9'h111, 1, 9'h122, 1, 1);
        step(0, 1, 9'h111, 1, 9'h122, 1, 1);
        repeat (6) step(0, 0, '0, 0, '0, 1, 1);

        // random traffic
        repeat (600) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 1) == 1, DW'($urandom),
                 $urandom_range(0, 1) == 1, DW'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        repeat (10) step(0, 0, '0, 0, '0, 1, 1);
        check("sb_drained", 32'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/merge_arb_node.md
MERGE_ARB_NODE -- requirements
Module: merge_arb_node

Interface
REQ-001 SHALL have parameter DW, default 9: packet width; bits [DW-1:DW-4] are the 4-bit destination address, the rest payload.
REQ-002 SHALL have parameter SW, default 1: width of the select-token channel.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in0_data, input, DW: packet from child 0.
REQ-006 SHALL have port in0_valid / in0_ready, input / output, 1 each: child 0 handshake.
REQ-007 SHALL have port in1_data, input, DW: packet from child 1.
REQ-008 SHALL have port in1_valid / in1_ready, input / output, 1 each: child 1 handshake.
REQ-009 SHALL have port out_data, output, DW: merged packet toward the parent.
REQ-010 SHALL have port out_valid / out_ready, output / input, 1 each: parent data handshake.
REQ-011 SHALL have port s_data, output, SW: select token, 0 = packet came from in0, 1 = from in1.
REQ-012 SHALL have port s_valid / s_ready, output / input, 1 each: select-token handshake.

Function
REQ-013 SHALL use the same handshake rule on every channel: transfer when valid && ready on a rising edge; a raised valid and its data stay stable until the transfer.
REQ-014 SHALL implement FSM states IDLE, SEND_S, SEND_D.
REQ-015 SHALL, in IDLE, assert inX_ready only for the granted input; no grant when neither input is valid.
REQ-016 SHALL, on an input transfer, capture the packet and source index, then go to SEND_S.
REQ-017 SHALL, in SEND_S, hold s_valid=1 with s_data=source index; on s transfer go to SEND_D.
REQ-018 SHALL, in SEND_D, hold out_valid=1 with out_data equal to the captured packet, unmodified.
REQ-019 SHALL, on out transfer, accept a new granted input in the same cycle (go to SEND_S) if one is valid, else go to IDLE.
REQ-020 SHALL order tokens strictly: s transfer precedes its out transfer; never s_valid && out_valid together.
REQ-021 SHALL meet latency: input transfer at cycle N gives s_valid at N+1; with s_ready=out_ready=1, out transfer at N+2; throughput 1 packet per 2 cycles.
REQ-022 SHALL arbitrate per REQ-029/030 when both inputs are valid in an accepting cycle; a lone valid input is always granted.
REQ-023 SHALL update the last-grant pointer only on an input transfer.
REQ-024 SHALL never assert both in0_ready and in1_ready.

Reset
REQ-025 SHALL, while reset=1, force the state to IDLE and set in0_ready=in1_ready=s_valid=out_valid=0, s_data=0, out_data=0.
REQ-026 SHALL set the last-grant pointer to 1 on reset, so in0 wins the first contention.
REQ-027 SHALL discard any packet captured but not yet delivered when reset asserts mid-operation, with no partial token emitted afterward.
REQ-028 SHALL accept inputs from the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with MERGE_RR_EN defined, arbitrate round-robin: on contention grant the input that is not the last-grant pointer.
REQ-030 SHALL, without MERGE_RR_EN, use fixed priority: in0 always wins contention, and the pointer is unused.

Structure
REQ-031 SHALL place DW default, the address field offsets, the packet typedef and the FSM state enum in the shared package noc_pkg.
REQ-032 SHALL implement grant logic in sub-module rr_arb2 (req[1:0], last, grant[1:0]), instantiated once.

Verification
REQ-033 SHALL cover a lone input: in0 sends 9'h1A5, ready lines high -> s_data=0 at N+1, out_data=9'h1A5 at N+2, in1_ready stays 0.
REQ-034 SHALL cover contention with MERGE_RR_EN: both valid continuously (in0=9'h101, in1=9'h0F2) -> s sequence 0,1,0,1 and out sequence alternates to match.
REQ-035 SHALL cover contention without MERGE_RR_EN: same stimulus -> only in0 packets and s_data=0 until in0_valid drops.
REQ-036 SHALL cover backpressure: out_ready=0 for 5 cycles in SEND_D -> out_valid/out_data stable, both inX_ready=0, then a single transfer.
REQ-037 SHALL cover s backpressure: s_ready=0 for 3 cycles -> s_valid held, out_valid=0 throughout.
REQ-038 SHALL cover reset mid-packet: reset in SEND_S -> next cycle all valids 0, no out transfer for the dropped packet, in0 granted first after release.
